// File: rtl/dpram_bist_pkg.sv
// Shared types and helpers for the dual-port RAM self-test controller.
// Optional feature macro used elsewhere in this slice: DPRAM_BIST_ERRCNT_EN.
package dpram_bist_pkg;

    localparam int PASS_COUNT = 2;
    localparam int PAT_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Test word for an address; callers truncate to their data width.
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                             input logic [PAT_W-1:0] seed,
                                             input logic             inv);
        logic [PAT_W-1:0] p_s;
        p_s = addr ^ seed;
        if (inv) begin
            pat = ~p_s;
        end else begin
            pat = p_s;
        end
    endfunction

endpackage

// File: rtl/dpram_bist_if.sv
// RAM-side bus between the self-test controller (master) and the dual-port RAM (slave).
interface dpram_bist_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  we_a;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output addr_a, addr_b, data_a, data_b, we_a, we_b,
        input  q_a, q_b
    );

    modport slave (
        input  addr_a, addr_b, data_a, data_b, we_a, we_b,
        output q_a, q_b
    );
endinterface

// File: rtl/dpram_bist_check.sv
// Expected-data pipeline, dual read-back comparators and first-fail capture.
// With DPRAM_BIST_ERRCNT_EN defined, also a saturating 8-bit mismatch counter.
module dpram_bist_check
    import dpram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_acc,
    input  logic                  cmp_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_exp_a,
    input  logic [DATA_WIDTH-1:0] rd_exp_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
`ifdef DPRAM_BIST_ERRCNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  mismatch
);

    logic                  exp_vld_r;
    logic [ADDR_WIDTH-1:0] exp_addr_a_r;
    logic [ADDR_WIDTH-1:0] exp_addr_b_r;
    logic [DATA_WIDTH-1:0] exp_a_r;
    logic [DATA_WIDTH-1:0] exp_b_r;
    logic                  mis_a_s;
    logic                  mis_b_s;
    logic                  fail_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic [DATA_WIDTH-1:0] fail_data_r;

    // Hold the expectation for one cycle to line up with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            exp_vld_r    <= 1'b0;
            exp_addr_a_r <= '0;
            exp_addr_b_r <= '0;
            exp_a_r      <= '0;
            exp_b_r      <= '0;
        end else begin
            exp_vld_r <= rd_en;
            if (rd_en) begin
                exp_addr_a_r <= rd_addr_a;
                exp_addr_b_r <= rd_addr_b;
                exp_a_r      <= rd_exp_a;
                exp_b_r      <= rd_exp_b;
            end
        end
    end

    assign mis_a_s  = cmp_en && exp_vld_r && (q_a != exp_a_r);
    assign mis_b_s  = cmp_en && exp_vld_r && (q_b != exp_b_r);
    assign mismatch = mis_a_s || mis_b_s;

    // First mismatch wins; port A takes priority when both ports miss together.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            fail_r      <= 1'b0;
            fail_addr_r <= '0;
            fail_data_r <= '0;
        end else if (mismatch && !fail_r) begin
            fail_r <= 1'b1;
            if (mis_a_s) begin
                fail_addr_r <= exp_addr_a_r;
                fail_data_r <= q_a;
            end else begin
                fail_addr_r <= exp_addr_b_r;
                fail_data_r <= q_b;
            end
        end
    end

    assign fail      = fail_r;
    assign fail_addr = fail_addr_r;
    assign fail_data = fail_data_r;

`ifdef DPRAM_BIST_ERRCNT_EN
    logic [7:0] err_cnt_r;
    logic [8:0] err_sum_s;

    assign err_sum_s = {1'b0, err_cnt_r} + 9'(mis_a_s) + 9'(mis_b_s);

    // Saturating count of every mismatching port compare.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_cnt_r <= 8'd0;
        end else if (err_sum_s > 9'd255) begin
            err_cnt_r <= 8'd255;
        end else begin
            err_cnt_r <= err_sum_s[7:0];
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule

// File: rtl/dpram_bist_ctrl.sv
// Two-pass cross-port write/read-back self-test controller for a single-clock dual-port RAM.
// Define DPRAM_BIST_ERRCNT_EN to run to completion and count all mismatches on err_count.
module dpram_bist_ctrl
    import dpram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
`ifdef DPRAM_BIST_ERRCNT_EN
    output logic [7:0]            err_count,
`endif
    dpram_bist_if.master          bus
);

    localparam int              K_W       = ADDR_WIDTH - 1;
    localparam logic [K_W-1:0]  K_LAST    = '1;
    localparam logic            LAST_PASS = 1'(PASS_COUNT - 1);
`ifdef DPRAM_BIST_ERRCNT_EN
    localparam logic            STOP_ON_FAIL = 1'b0;
`else
    localparam logic            STOP_ON_FAIL = 1'b1;
`endif

    bist_state_e           state_r, state_nx_s;
    logic                  pass_r, pass_nx_s;
    logic [K_W-1:0]        k_r, k_nx_s;
    logic                  start_acc_s;
    logic                  mismatch_s;
    logic                  stop_s;
    logic                  rd_en_s;
    logic [ADDR_WIDTH-1:0] addr_even_s;
    logic [ADDR_WIDTH-1:0] addr_odd_s;
    logic [DATA_WIDTH-1:0] pat_even_s;
    logic [DATA_WIDTH-1:0] pat_odd_s;

    assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign stop_s      = mismatch_s && STOP_ON_FAIL;
    assign addr_even_s = {k_r, 1'b0};
    assign addr_odd_s  = {k_r, 1'b1};
    assign pat_even_s  = DATA_WIDTH'(pat(PAT_W'(addr_even_s), PAT_W'(PATTERN), pass_r));
    assign pat_odd_s   = DATA_WIDTH'(pat(PAT_W'(addr_odd_s), PAT_W'(PATTERN), pass_r));

    // State, pass and half-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pass_r  <= 1'b0;
            k_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            pass_r  <= pass_nx_s;
            k_r     <= k_nx_s;
        end
    end

    // Next-state logic; k returns to zero on every state change.
    always_comb begin
        state_nx_s = state_r;
        pass_nx_s  = pass_r;
        k_nx_s     = k_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    state_nx_s = ST_WRITE;
                    pass_nx_s  = 1'b0;
                    k_nx_s     = '0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WRITE: begin
                k_nx_s = k_r + K_W'(1);
                if (k_r == K_LAST) begin
                    state_nx_s = ST_READ;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (stop_s) begin
                    state_nx_s = ST_DONE;
                    k_nx_s     = '0;
                end else if (k_r == K_LAST) begin
                    state_nx_s = ST_DRAIN;
                    k_nx_s     = '0;
                end else begin
                    state_nx_s = ST_READ;
                    k_nx_s     = k_r + K_W'(1);
                end
            end
            ST_DRAIN: begin
                k_nx_s = '0;
                if (stop_s || (pass_r == LAST_PASS)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WRITE;
                    pass_nx_s  = LAST_PASS;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pass_nx_s  = 1'b0;
                k_nx_s     = '0;
            end
        endcase
    end

    // RAM-side decode: writes go straight, reads are crossed between ports.
    always_comb begin
        bus.addr_a = '0;
        bus.addr_b = '0;
        bus.data_a = '0;
        bus.data_b = '0;
        bus.we_a   = 1'b0;
        bus.we_b   = 1'b0;
        rd_en_s    = 1'b0;
        case (state_r)
            ST_WRITE: begin
                bus.addr_a = addr_even_s;
                bus.addr_b = addr_odd_s;
                bus.data_a = pat_even_s;
                bus.data_b = pat_odd_s;
                bus.we_a   = 1'b1;
                bus.we_b   = 1'b1;
            end
            ST_READ: begin
                bus.addr_a = addr_odd_s;
                bus.addr_b = addr_even_s;
                rd_en_s    = 1'b1;
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    assign busy = (state_r == ST_WRITE) || (state_r == ST_READ) || (state_r == ST_DRAIN);
    assign done = (state_r == ST_DONE);

    dpram_bist_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_check (
        .clk        (clk),
        .rst        (rst),
        .start_acc  (start_acc_s),
        .cmp_en     (busy),
        .rd_en      (rd_en_s),
        .rd_addr_a  (addr_odd_s),
        .rd_addr_b  (addr_even_s),
        .rd_exp_a   (pat_odd_s),
        .rd_exp_b   (pat_even_s),
        .q_a        (bus.q_a),
        .q_b        (bus.q_b),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
`ifdef DPRAM_BIST_ERRCNT_EN
        .err_count  (err_count),
`endif
        .mismatch   (mismatch_s)
    );

endmodule
